// File: rtl/axis_marker_checker.sv
// Terminal AXI-stream sink checking fill words, packet markers and packet length.
// Define MARKER_CHECK_RESYNC_EN to resync the expected marker after a mismatch.
module axis_marker_checker #(
   parameter logic [31:0] FILL_PATTERN = 32'hABCDBEEF,
   parameter int unsigned CNT_WIDTH    = 32,
   parameter logic [15:0] MAX_PKT_LEN  = 16'd1024
) (
   input  logic                 ce_clk,
   input  logic                 ce_rst,
   input  logic                 clear,
   input  logic [31:0]          s_axis_tdata,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic                 locked,
   output logic [31:0]          last_marker,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic [CNT_WIDTH-1:0] marker_err_count,
   output logic [CNT_WIDTH-1:0] fill_err_count,
   output logic [CNT_WIDTH-1:0] len_err_count,
   output logic                 err_stb
);

   localparam logic [0:0] ST_ACQUIRE = 1'b0;
   localparam logic [0:0] ST_TRACK   = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [16:0]          LEN_LIM = {1'b0, MAX_PKT_LEN};
   localparam logic [16:0]          BEAT_MAX = 17'h1FFFF;

   logic [0:0]           state_q, state_d;
   logic [31:0]          expected_q, expected_d;
   logic [16:0]          beat_cnt_q, beat_cnt_d;
   logic                 len_flag_q, len_flag_d;
   logic                 tready_q, tready_d;
   logic [31:0]          last_marker_q, last_marker_d;
   logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
   logic [CNT_WIDTH-1:0] marker_err_q, marker_err_d;
   logic [CNT_WIDTH-1:0] fill_err_q, fill_err_d;
   logic [CNT_WIDTH-1:0] len_err_q, len_err_d;
   logic                 err_stb_q, err_stb_d;

   logic        accept;
   logic [16:0] beat_nxt;
   logic        fill_err;
   logic        len_err;
   logic        mark_err;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(
      input logic [CNT_WIDTH-1:0] c
   );
      sat_inc = (c == CNT_MAX) ? c : c + CNT_ONE;
   endfunction

   assign accept   = s_axis_tvalid & tready_q;
   assign beat_nxt = (beat_cnt_q == BEAT_MAX) ? beat_cnt_q
                                              : beat_cnt_q + 17'd1;
   assign fill_err = accept & ~s_axis_tlast
                     & (s_axis_tdata != FILL_PATTERN);
   assign len_err  = accept & (beat_nxt > LEN_LIM) & ~len_flag_q;
   assign mark_err = accept & s_axis_tlast & (state_q == ST_TRACK)
                     & (s_axis_tdata != expected_q);

   always_comb begin
      state_d       = state_q;
      expected_d    = expected_q;
      beat_cnt_d    = beat_cnt_q;
      len_flag_d    = len_flag_q;
      tready_d      = 1'b1;
      last_marker_d = last_marker_q;
      pkt_count_d   = pkt_count_q;
      marker_err_d  = marker_err_q;
      fill_err_d    = fill_err_q;
      len_err_d     = len_err_q;
      err_stb_d     = 1'b0;

      if (clear) begin
         // clear wins over a beat accepted in the same cycle
         state_d       = ST_ACQUIRE;
         expected_d    = 32'd0;
         beat_cnt_d    = 17'd0;
         len_flag_d    = 1'b0;
         last_marker_d = 32'd0;
         pkt_count_d   = '0;
         marker_err_d  = '0;
         fill_err_d    = '0;
         len_err_d     = '0;
      end else if (accept) begin
         err_stb_d = fill_err | len_err | mark_err;
         if (fill_err) fill_err_d = sat_inc(fill_err_q);
         if (len_err)  len_err_d  = sat_inc(len_err_q);
         if (s_axis_tlast) begin
            pkt_count_d   = pkt_count_q + CNT_ONE;
            last_marker_d = s_axis_tdata;
            beat_cnt_d    = 17'd0;
            len_flag_d    = 1'b0;
            if (state_q == ST_ACQUIRE) begin
               expected_d = s_axis_tdata + 32'd1;
               state_d    = ST_TRACK;
            end else if (!mark_err) begin
               expected_d = expected_q + 32'd1;
            end else begin
               marker_err_d = sat_inc(marker_err_q);
`ifdef MARKER_CHECK_RESYNC_EN
               expected_d = s_axis_tdata + 32'd1;
`else
               expected_d = expected_q + 32'd1;
`endif
            end
         end else begin
            beat_cnt_d = beat_nxt;
            len_flag_d = len_flag_q | len_err;
         end
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         state_q       <= ST_ACQUIRE;
         expected_q    <= 32'd0;
         beat_cnt_q    <= 17'd0;
         len_flag_q    <= 1'b0;
         tready_q      <= 1'b0;
         last_marker_q <= 32'd0;
         pkt_count_q   <= '0;
         marker_err_q  <= '0;
         fill_err_q    <= '0;
         len_err_q     <= '0;
         err_stb_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         beat_cnt_q    <= beat_cnt_d;
         len_flag_q    <= len_flag_d;
         tready_q      <= tready_d;
         last_marker_q <= last_marker_d;
         pkt_count_q   <= pkt_count_d;
         marker_err_q  <= marker_err_d;
         fill_err_q    <= fill_err_d;
         len_err_q     <= len_err_d;
         err_stb_q     <= err_stb_d;
      end
   end

   assign s_axis_tready    = tready_q;
   assign locked           = (state_q == ST_TRACK);
   assign last_marker      = last_marker_q;
   assign pkt_count        = pkt_count_q;
   assign marker_err_count = marker_err_q;
   assign fill_err_count   = fill_err_q;
   assign len_err_count    = len_err_q;
   assign err_stb          = err_stb_q;

endmodule

// File: tb/tb_axis_marker_checker.sv
// Directed bench for axis_marker_checker with MAX_PKT_LEN = 8.
module tb_axis_marker_checker;

   localparam logic [31:0] FILL = 32'hABCDBEEF;

   logic        ce_clk = 1'b0;
   logic        ce_rst = 1'b1;
   logic        clear = 1'b0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        locked;
   logic [31:0] last_marker;
   logic [31:0] pkt_count;
   logic [31:0] marker_err_count;
   logic [31:0] fill_err_count;
   logic [31:0] len_err_count;
   logic        err_stb;

   int errors = 0;
   int checks = 0;
   int stb_n  = 0;

   axis_marker_checker #(
      .FILL_PATTERN(FILL),
      .CNT_WIDTH(32),
      .MAX_PKT_LEN(16'd8)
   ) dut (
      .ce_clk(ce_clk),
      .ce_rst(ce_rst),
      .clear(clear),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .locked(locked),
      .last_marker(last_marker),
      .pkt_count(pkt_count),
      .marker_err_count(marker_err_count),
      .fill_err_count(fill_err_count),
      .len_err_count(len_err_count),
      .err_stb(err_stb)
   );

   always #5 ce_clk = ~ce_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic l);
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      @(posedge ce_clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (err_stb) stb_n++;
   endtask

   task automatic pkt(input logic [31:0] marker, input int nfill);
      for (int i = 0; i < nfill; i++) beat(FILL, 1'b0);
      beat(marker, 1'b1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge ce_clk); #1;
      clear = 1'b0;
      stb_n = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdy"}, {31'd0, s_axis_tready}, 32'd0);
      check({tag, "_lock"}, {31'd0, locked}, 32'd0);
      check({tag, "_last"}, last_marker, 32'd0);
      check({tag, "_pkt"}, pkt_count, 32'd0);
      check({tag, "_merr"}, marker_err_count, 32'd0);
      check({tag, "_ferr"}, fill_err_count, 32'd0);
      check({tag, "_lerr"}, len_err_count, 32'd0);
      check({tag, "_stb"}, {31'd0, err_stb}, 32'd0);
   endtask

   initial begin
      #2;
      check_all_zero("rst");
      #10 ce_rst = 1'b0;
      @(posedge ce_clk); #1;
      check("rdy_up", {31'd0, s_axis_tready}, 32'd1);

      // three 4-beat packets
      pkt(32'd5, 3);
      check("t1_lock", {31'd0, locked}, 32'd1);
      pkt(32'd6, 3);
      pkt(32'd7, 3);
      check("t1_pkt", pkt_count, 32'd3);
      check("t1_last", last_marker, 32'd7);
      check("t1_merr", marker_err_count, 32'd0);
      check("t1_ferr", fill_err_count, 32'd0);
      check("t1_lerr", len_err_count, 32'd0);

      // dropped marker 12
      do_clear();
      check("t2_clr_lock", {31'd0, locked}, 32'd0);
      pkt(32'd10, 0);
      pkt(32'd11, 0);
      pkt(32'd13, 0);
      pkt(32'd14, 0);
      check("t2_pkt", pkt_count, 32'd4);
`ifdef MARKER_CHECK_RESYNC_EN
      check("t2_merr", marker_err_count, 32'd1);
`else
      check("t2_merr", marker_err_count, 32'd2);
`endif

      // corrupted second beat
      do_clear();
      beat(FILL, 1'b0);
      beat(32'd0, 1'b0);
      check("t3_stb_on", {31'd0, err_stb}, 32'd1);
      beat(FILL, 1'b0);
      check("t3_stb_off", {31'd0, err_stb}, 32'd0);
      beat(32'd1, 1'b1);
      check("t3_ferr", fill_err_count, 32'd1);
      check("t3_stb_n", stb_n, 32'd1);

      // marker wrap
      do_clear();
      pkt(32'hFFFFFFFE, 0);
      pkt(32'hFFFFFFFF, 0);
      pkt(32'h00000000, 0);
      check("t4_merr", marker_err_count, 32'd0);
      check("t4_last", last_marker, 32'd0);
      check("t4_stb_n", stb_n, 32'd0);

      // 10-beat packet against limit 8, then a 4-beat one
      do_clear();
      for (int i = 1; i <= 9; i++) begin
         beat(FILL, 1'b0);
         if (i == 8) check("t5_b8", {31'd0, err_stb}, 32'd0);
         if (i == 9) check("t5_b9", {31'd0, err_stb}, 32'd1);
      end
      beat(32'd1, 1'b1);
      check("t5_b10", {31'd0, err_stb}, 32'd0);
      pkt(32'd2, 3);
      check("t5_lerr", len_err_count, 32'd1);
      check("t5_pkt", pkt_count, 32'd2);
      check("t5_stb_n", stb_n, 32'd1);
      check("t5_merr", marker_err_count, 32'd0);

      // clear beats a simultaneous tlast
      do_clear();
      pkt(32'd3, 0);
      check("t6_lock_pre", {31'd0, locked}, 32'd1);
      clear = 1'b1;
      beat(32'd4, 1'b1);
      clear = 1'b0;
      check("t6_pkt", pkt_count, 32'd0);
      check("t6_lock", {31'd0, locked}, 32'd0);
      check("t6_last", last_marker, 32'd0);
      check("t6_rdy", {31'd0, s_axis_tready}, 32'd1);

      // reset mid-packet
      beat(FILL, 1'b0);
      beat(32'd0, 1'b0);
      check("t6_ferr_pre", fill_err_count, 32'd1);
      #3 ce_rst = 1'b1;
      #1;
      check_all_zero("t6_rst");
      #10 ce_rst = 1'b0;
      @(posedge ce_clk); #1;
      check("t6_rdy_up", {31'd0, s_axis_tready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
